// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem requests and
// buffers returned words with their PCs for the decoder; redirects flush the stream.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C  = CW1'(FIFO_DEPTH);

    logic [31:0]   pc;
    logic [31:0]   pend_pc   [FIFO_DEPTH];
    logic [PW-1:0] pend_wr;
    logic [PW-1:0] pend_rd;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic          pop;
    logic          accept;
    logic          push;
    logic [CW:0]   credits_used;
    logic [CW-1:0] outstanding_next;
    logic          unused_redirect_bits;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // A slot freed by this cycle's pop may be re-issued immediately, so the
    // request valid looks through inst_ready.
    assign pop              = inst_valid & inst_ready;
    assign credits_used     = CW1'(outstanding) + CW1'(fifo_count) - CW1'(pop);
    assign imem_req_valid   = !rst && (credits_used < DEPTH_C);
    assign imem_req_addr    = pc;
    assign accept           = imem_req_valid & imem_req_ready;
    assign push             = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);

    assign inst_valid = (fifo_count != '0);
    assign inst       = fifo_word[fifo_rd];
    assign inst_pc    = fifo_pc[fifo_rd];

    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            pend_wr     <= '0;
            pend_rd     <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pend_pc[i]   <= '0;
                fifo_pc[i]   <= '0;
                fifo_word[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (accept) begin
                pend_pc[pend_wr] <= pc;
                pend_wr          <= next_idx(pend_wr);
            end
            if (imem_resp_valid) begin
                pend_rd <= next_idx(pend_rd);
            end
            if (push) begin
                fifo_pc[fifo_wr]   <= pend_pc[pend_rd];
                fifo_word[fifo_wr] <= imem_resp_data;
                fifo_wr            <= next_idx(fifo_wr);
            end
            // Redirect overrides the normal bookkeeping: everything still in
            // flight after this edge belongs to the old path and is dropped.
            if (redirect_valid) begin
                pc         <= {redirect_pc[31:2], 2'b00};
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
                drop       <= outstanding_next;
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (pop) begin
                    fifo_rd <= next_idx(fifo_rd);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
                if (imem_resp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: hand-derived vector tables, directed redirect/reset
// sequences and a randomized run against a queue-based model of the fetch stream.
module tb_riscv_fetch;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_req_t;

    typedef struct {
        bit          rst;
        bit          req_ready;
        bit          inst_ready;
        bit          exp_req_valid;
        logic [31:0] exp_req_addr;
        bit          chk_inst;
        bit          exp_inst_valid;
        logic [31:0] exp_inst_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        w_rst;
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_req_ready;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    int          epoch = 0;
    int          lat = 1;
    int          delivered = 0;
    bit          prev_rst = 1'b1;
    bit          resp_now = 1'b0;
    mem_req_t    cur_resp;
    mem_req_t    mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] req_pc = 32'h0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    riscv_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready)
    );

    riscv_fetch #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
        .imem_req_ready(w_req_ready),
        .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
        .inst_ready(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory side: the oldest request whose latency has elapsed answers now.
    task automatic begin_cycle();
        cycle++;
        resp_now        = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cycle) begin
            cur_resp        = mem_q.pop_front();
            resp_now        = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = cur_resp.addr ^ KEY;
        end
        @(negedge clk);
    endtask

    // Model: requests are tagged with the redirect epoch they were issued in;
    // only current-epoch words reach the buffer, which the decoder drains in order.
    task automatic end_cycle();
        int outst;
        int used;
        bit pop_e;
        bit exp_rv;
        if (rst) begin
            check("reset_req_valid", imem_req_valid, 0);
            if (prev_rst) begin
                check("reset_inst_valid", inst_valid, 0);
                check("reset_inst", inst, 0);
                check("reset_inst_pc", inst_pc, 0);
            end
            buf_q.delete();
            mem_q.delete();
            req_pc = 32'h0;
        end else begin
            outst  = mem_q.size() + (resp_now ? 1 : 0);
            pop_e  = (buf_q.size() > 0) && inst_ready;
            used   = outst + buf_q.size() - (pop_e ? 1 : 0);
            exp_rv = (used < 2);
            check("req_valid", imem_req_valid, exp_rv);
            check("inst_valid", inst_valid, buf_q.size() > 0);
            if (buf_q.size() > 0) begin
                check("inst_pc", inst_pc, buf_q[0]);
                check("inst_word", inst, buf_q[0] ^ KEY);
            end
            if (exp_rv && imem_req_ready) begin
                check("req_addr", imem_req_addr, req_pc);
                mem_q.push_back('{addr: req_pc, epoch: epoch, due: cycle + lat});
                req_pc = req_pc + 32'd4;
            end
            if (pop_e) begin
                void'(buf_q.pop_front());
                delivered++;
            end
            if (resp_now && cur_resp.epoch == epoch && !redirect_valid) begin
                buf_q.push_back(cur_resp.addr);
            end
            if (redirect_valid) begin
                buf_q.delete();
                epoch++;
                req_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        prev_rst = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        run_cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_inst(input string name, input logic [31:0] exp_pc, input int bound,
                             output int waited);
        waited = 0;
        for (int i = 0; i < bound; i++) begin
            begin_cycle();
            waited++;
            if (inst_valid) begin
                check({name, "_pc"}, inst_pc, exp_pc);
                check({name, "_word"}, inst, exp_pc ^ KEY);
                end_cycle();
                return;
            end
            end_cycle();
        end
        tests++;
        fails++;
        $display("[TB] FAIL %s_timeout: no inst_valid within %0d cycles, expected pc %h",
                 name, bound, exp_pc);
    endtask

    function automatic void add_vec(bit r, bit rr, bit ir, bit erv, logic [31:0] ea,
                                    bit ci, bit eiv, logic [31:0] epc);
        vec_t v;
        v.rst = r;  v.req_ready = rr;  v.inst_ready = ir;
        v.exp_req_valid = erv;  v.exp_req_addr = ea;
        v.chk_inst = ci;  v.exp_inst_valid = eiv;  v.exp_inst_pc = epc;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        imem_req_ready = v.req_ready;
        inst_ready     = v.inst_ready;
        redirect_valid = 1'b0;
        begin_cycle();
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("vec%0d_req_valid", idx), imem_req_valid, v.exp_req_valid);
        if (v.exp_req_valid) begin
            check($sformatf("vec%0d_req_addr", idx), imem_req_addr, v.exp_req_addr);
        end
        if (v.chk_inst) begin
            check($sformatf("vec%0d_inst_valid", idx), inst_valid, v.exp_inst_valid);
            if (v.exp_inst_valid) begin
                check($sformatf("vec%0d_inst_pc", idx), inst_pc, v.exp_inst_pc);
                check($sformatf("vec%0d_inst", idx), inst, v.exp_inst_pc ^ KEY);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        int d0;

        rst = 1'b1;  imem_req_ready = 1'b0;  imem_resp_valid = 1'b0;  imem_resp_data = '0;
        redirect_valid = 1'b0;  redirect_pc = '0;  inst_ready = 1'b0;
        w_rst = 1'b1;  w_req_ready = 1'b0;

        // Zero-wait stream from reset, then a 10-cycle decoder stall.
        add_vec(1, 1, 1, 0, 0, 1, 0, 0);
        add_vec(1, 1, 1, 0, 0, 1, 0, 0);
        add_vec(0, 1, 1, 1, 32'd0, 1, 0, 0);
        add_vec(0, 1, 1, 1, 32'd4, 1, 0, 0);
        add_vec(0, 1, 1, 1, 32'd8, 1, 1, 32'd0);
        add_vec(0, 1, 1, 1, 32'd12, 1, 1, 32'd4);
        add_vec(0, 1, 1, 1, 32'd16, 1, 1, 32'd8);
        add_vec(0, 1, 1, 1, 32'd20, 1, 1, 32'd12);
        add_vec(1, 1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 1, 0, 0, 0, 1, 0, 0);
        add_vec(0, 1, 0, 1, 32'd0, 1, 0, 0);
        add_vec(0, 1, 0, 1, 32'd4, 1, 0, 0);
        for (int i = 0; i < 8; i++) add_vec(0, 1, 0, 0, 0, 1, 1, 32'd0);
        add_vec(0, 1, 1, 1, 32'd8, 1, 1, 32'd0);
        add_vec(0, 1, 1, 1, 32'd12, 1, 1, 32'd4);
        add_vec(0, 1, 1, 1, 32'd16, 1, 1, 32'd8);

        @(posedge clk);
        #1;

        // RESET_PC near the top of memory: the second fetch wraps to 0.
        @(negedge clk);
        check("wrap_reset_req_valid", w_req_valid, 0);
        check("wrap_reset_inst_valid", w_inst_valid, 0);
        @(posedge clk); #1;
        w_rst = 1'b0;  w_req_ready = 1'b1;
        @(negedge clk);
        check("wrap_first_valid", w_req_valid, 1);
        check("wrap_first_addr", w_req_addr, WRAP_PC);
        @(posedge clk); #1;
        @(negedge clk);
        check("wrap_second_valid", w_req_valid, 1);
        check("wrap_second_addr", w_req_addr, 32'h0);
        @(posedge clk); #1;
        w_rst = 1'b1;

        lat = 1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
            end_cycle();
        end

        // Latency 3 with request ready toggling every other cycle.
        lat = 3;
        do_reset();
        inst_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 40; i++) begin
            imem_req_ready = (i % 2 == 0);
            begin_cycle();
            end_cycle();
        end
        check("lat3_progress", (delivered - d0) >= 8, 1);

        // Redirect to 0x100 with two requests in flight.
        lat = 3;
        do_reset();
        inst_ready = 1'b1;  imem_req_ready = 1'b1;
        run_cycles(3);
        redirect_valid = 1'b1;  redirect_pc = 32'h100;
        begin_cycle();
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        check("redir_next_valid", imem_req_valid, 1);
        check("redir_next_addr", imem_req_addr, 32'h100);
        end_cycle();
        wait_inst("redir_first", 32'h100, 20, waited);
        check("redir_inst_delay", waited, 4);

        // Redirect coinciding with both a response and an accept; low bits ignored.
        lat = 1;
        do_reset();
        inst_ready = 1'b1;  imem_req_ready = 1'b1;
        run_cycles(5);
        redirect_valid = 1'b1;  redirect_pc = 32'h203;
        begin_cycle();
        check("coinc_accept", imem_req_valid, 1);
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        check("coinc_next_addr", imem_req_addr, 32'h200);
        end_cycle();
        wait_inst("coinc_first", 32'h200, 10, waited);

        // Reset pulsed mid-stream.
        run_cycles(6);
        rst = 1'b1;
        begin_cycle();
        end_cycle();
        rst = 1'b0;
        begin_cycle();
        check("post_rst_inst_valid", inst_valid, 0);
        check("post_rst_req_valid", imem_req_valid, 1);
        check("post_rst_req_addr", imem_req_addr, 32'h0);
        end_cycle();

        // Randomized traffic against the model.
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            lat            = $urandom_range(1, 4);
            redirect_valid = !rst && ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
            begin_cycle();
            end_cycle();
        end
        check("random_progress", (delivered - d0) > 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
